// File: rtl/scaler_linear_h_mc.sv
// Multi-channel horizontal linear scaler: one shared bilinear weight pair per output, CH_COUNT lanes.
// Optional macro SCALER_H_INIT_PHASE_EN adds h_init_phase as the per-line starting output coordinate.
module scaler_linear_h_mc #(
    parameter int CH_COUNT    = 3,
    parameter int PIXEL_WIDTH = 12,
    parameter int PIXEL_STEP  = 4096,
    parameter int COE_WIDTH   = 10,
    parameter int CNT_WIDTH   = 24,
    parameter int DST_W_WIDTH = 12
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [15:0]                     h_scale_step,
    input  logic [DST_W_WIDTH-1:0]          dst_width,
`ifdef SCALER_H_INIT_PHASE_EN
    input  logic [15:0]                     h_init_phase,
`endif
    input  logic [CH_COUNT*PIXEL_WIDTH-1:0] di_i,
    input  logic                            de_i,
    input  logic                            hs_i,
    input  logic                            vs_i,
    output logic [CH_COUNT*PIXEL_WIDTH-1:0] do_o,
    output logic                            de_o,
    output logic                            hs_o,
    output logic                            vs_o,
    output logic                            line_short_o,
    output logic                            overrun_o
);
    localparam int DW      = CH_COUNT * PIXEL_WIDTH;
    localparam int FRAC_W  = $clog2(PIXEL_STEP);
    localparam int W_SHIFT = FRAC_W - (COE_WIDTH - 1);
    localparam int PRODW   = PIXEL_WIDTH + COE_WIDTH;
    localparam int SUMW    = PRODW + 1;
    localparam logic [CNT_WIDTH:0]   STEP1 = (CNT_WIDTH+1)'(PIXEL_STEP);
    localparam logic [COE_WIDTH-1:0] W_ONE = COE_WIDTH'(2 ** (COE_WIDTH - 1));
    localparam logic [SUMW-1:0]      RND   = SUMW'(2 ** (COE_WIDTH - 2));

    logic [DW-1:0]          t0_q, t0_d, t1_q, t1_d;
    logic [CNT_WIDTH-1:0]   cnt_i_q, cnt_i_d, cnt_o_q, cnt_o_d, cnt_o_init;
    logic [DST_W_WIDTH-1:0] out_cnt_q, out_cnt_d, dstw_q, dstw_d;
    logic [15:0]            step_q, step_d;
    logic                   active_q, active_d, pend_hs_q, pend_hs_d, pend_vs_q, pend_vs_d;
    logic                   short_q, short_d, over_q, over_d;

    logic                   line_start, emit, over_hit;
    logic [CNT_WIDTH:0]     cnt_i_x, cnt_o_int;

`ifdef SCALER_H_INIT_PHASE_EN
    assign cnt_o_init = CNT_WIDTH'(h_init_phase);
`else
    assign cnt_o_init = '0;
`endif

    // cnt_i only holds whole-pixel positions, so cnt_o is compared by its integer part.
    assign line_start = de_i & hs_i;
    assign cnt_i_x    = {1'b0, cnt_i_q};
    assign cnt_o_int  = {1'b0, cnt_o_q[CNT_WIDTH-1:FRAC_W], {FRAC_W{1'b0}}};
    assign emit       = active_q && !line_start && (out_cnt_q < dstw_q) &&
                        (cnt_i_x >= cnt_o_int + STEP1);
    assign over_hit   = emit && (cnt_i_x >= cnt_o_int + (STEP1 << 1));

    always_comb begin
        t0_d      = t0_q;
        t1_d      = t1_q;
        cnt_i_d   = cnt_i_q;
        cnt_o_d   = cnt_o_q;
        out_cnt_d = out_cnt_q;
        dstw_d    = dstw_q;
        step_d    = step_q;
        active_d  = active_q;
        pend_hs_d = pend_hs_q;
        pend_vs_d = pend_vs_q;
        short_d   = short_q;
        over_d    = over_q;
        if (line_start) begin
            t0_d      = t1_q;
            t1_d      = di_i;
            cnt_i_d   = '0;
            cnt_o_d   = cnt_o_init;
            out_cnt_d = '0;
            dstw_d    = dst_width;
            step_d    = h_scale_step;
            active_d  = 1'b1;
            pend_hs_d = 1'b1;
            pend_vs_d = vs_i;
            if (active_q && (out_cnt_q < dstw_q))
                short_d = 1'b1;
            if (vs_i) begin
                short_d = 1'b0;
                over_d  = 1'b0;
            end
        end else begin
            if (de_i && active_q) begin
                t0_d    = t1_q;
                t1_d    = di_i;
                cnt_i_d = cnt_i_q + CNT_WIDTH'(PIXEL_STEP);
            end
            if (emit) begin
                cnt_o_d   = cnt_o_q + CNT_WIDTH'(step_q);
                out_cnt_d = out_cnt_q + DST_W_WIDTH'(1);
                pend_hs_d = 1'b0;
                pend_vs_d = 1'b0;
                if (over_hit)
                    over_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t0_q <= '0; t1_q <= '0; cnt_i_q <= '0; cnt_o_q <= '0;
            out_cnt_q <= '0; dstw_q <= '0; step_q <= '0; active_q <= 1'b0;
            pend_hs_q <= 1'b0; pend_vs_q <= 1'b0; short_q <= 1'b0; over_q <= 1'b0;
        end else begin
            t0_q <= t0_d; t1_q <= t1_d; cnt_i_q <= cnt_i_d; cnt_o_q <= cnt_o_d;
            out_cnt_q <= out_cnt_d; dstw_q <= dstw_d; step_q <= step_d; active_q <= active_d;
            pend_hs_q <= pend_hs_d; pend_vs_q <= pend_vs_d; short_q <= short_d; over_q <= over_d;
        end
    end

    assign line_short_o = short_q;
    assign overrun_o    = over_q;

    // Datapath E -> multiply -> add/round -> output; de_o is a one-cycle strobe per output pixel.
    logic                   e_v_q, e_hs_q, e_vs_q, m_v_q, m_hs_q, m_vs_q, a_v_q, a_hs_q, a_vs_q;
    logic [DW-1:0]          e_t0_q, e_t1_q, a_px_q;
    logic [COE_WIDTH-1:0]   e_w1_q, e_w0;
    logic [PRODW-1:0]       m0_q [CH_COUNT];
    logic [PRODW-1:0]       m1_q [CH_COUNT];

    assign e_w0 = W_ONE - e_w1_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_v_q <= 1'b0; e_hs_q <= 1'b0; e_vs_q <= 1'b0;
            e_t0_q <= '0; e_t1_q <= '0; e_w1_q <= '0;
            m_v_q <= 1'b0; m_hs_q <= 1'b0; m_vs_q <= 1'b0;
            a_v_q <= 1'b0; a_hs_q <= 1'b0; a_vs_q <= 1'b0; a_px_q <= '0;
            for (int c = 0; c < CH_COUNT; c++) begin
                m0_q[c] <= '0;
                m1_q[c] <= '0;
            end
            do_o <= '0; de_o <= 1'b0; hs_o <= 1'b0; vs_o <= 1'b0;
        end else begin
            e_v_q <= emit;
            if (emit) begin
                e_t0_q <= t0_q;
                e_t1_q <= t1_q;
                e_w1_q <= COE_WIDTH'(cnt_o_q[FRAC_W-1:W_SHIFT]);
                e_hs_q <= pend_hs_q;
                e_vs_q <= pend_vs_q;
            end
            m_v_q  <= e_v_q;
            m_hs_q <= e_hs_q;
            m_vs_q <= e_vs_q;
            for (int c = 0; c < CH_COUNT; c++) begin
                m0_q[c] <= PRODW'(e_w0) * PRODW'(e_t0_q[c*PIXEL_WIDTH +: PIXEL_WIDTH]);
                m1_q[c] <= PRODW'(e_w1_q) * PRODW'(e_t1_q[c*PIXEL_WIDTH +: PIXEL_WIDTH]);
                a_px_q[c*PIXEL_WIDTH +: PIXEL_WIDTH] <=
                    PIXEL_WIDTH'((SUMW'(m0_q[c]) + SUMW'(m1_q[c]) + RND) >> (COE_WIDTH - 1));
            end
            a_v_q  <= m_v_q;
            a_hs_q <= m_hs_q;
            a_vs_q <= m_vs_q;
            de_o <= a_v_q;
            hs_o <= a_v_q & a_hs_q;
            vs_o <= a_v_q & a_vs_q;
            if (a_v_q)
                do_o <= a_px_q;
        end
    end
endmodule

// File: doc/scaler_linear_h_mc.md
Name: scaler_linear_h_mc

Overview:
Multi-channel horizontal linear scaler for the scaler2 video pipeline. It scales one line at a time by a runtime fixed-point step and applies the same bilinear weights to CH_COUNT packed channels in parallel. An output-width counter terminates each line, and sticky status flags report short lines and tap overrun. Output timing is fully deterministic.

Parameters:
CH_COUNT, 3, number of channels packed in di_i/do_o (channel c at bits [c*PIXEL_WIDTH +: PIXEL_WIDTH])
PIXEL_WIDTH, 12, bits per channel sample, unsigned
PIXEL_STEP, 4096, fixed-point 1.0 for coordinates; power of two
COE_WIDTH, 10, weight width; weights sum to 2^(COE_WIDTH-1); requires COE_WIDTH-1 <= log2(PIXEL_STEP)
CNT_WIDTH, 24, coordinate accumulator width
DST_W_WIDTH, 12, width of dst_width

Ports:
clk  in  1  pixel clock, rising edge
rst  in  1  asynchronous active-high reset
h_scale_step  in  16  source advance per output pixel, PIXEL_STEP = 1.0; sampled at line start
dst_width  in  DST_W_WIDTH  output pixels per line; sampled at line start
di_i  in  CH_COUNT*PIXEL_WIDTH  input pixel
de_i  in  1  input pixel valid
hs_i  in  1  first pixel of line, qualified by de_i
vs_i  in  1  first line of frame, qualified by de_i & hs_i
do_o  out  CH_COUNT*PIXEL_WIDTH  output pixel
de_o  out  1  output valid
hs_o  out  1  first output of line
vs_o  out  1  first output of frame
line_short_o  out  1  sticky: a line ended before dst_width outputs were emitted
overrun_o  out  1  sticky: taps no longer bracket the output coordinate

Behaviour:
- Reset: all outputs, counters, taps and flags go to 0. Reset mid-line discards the line; the block stays idle until the next de_i & hs_i.
- Accept (de_i=1):
  - Taps shift: t0 <= t1, t1 <= di_i.
  - cnt_i <= cnt_i + PIXEL_STEP.
- Line start (de_i & hs_i): cnt_i <= 0, cnt_o <= 0, out_cnt <= 0, t1 <= di_i. Latch h_scale_step and dst_width. A pending first-output flag arms hs_o. If vs_i is also high, arm vs_o and clear both sticky flags.
- Line start while the previous line has out_cnt < latched dst_width: set line_short_o; pending outputs of that line are dropped.
- Emission decision, registered stage E:
  - Condition: out_cnt < dst_width and cnt_i >= cnt_o + PIXEL_STEP.
  - On emit: capture (t0, t1) and frac = cnt_o mod PIXEL_STEP; cnt_o += step; out_cnt += 1.
  - At most one emission per clock. Decision uses a consistent registered (cnt_i, taps) pair, so simultaneous accept and emit is legal.
- Overrun: if the emission condition holds with cnt_i >= cnt_o + 2*PIXEL_STEP, set overrun_o. Emit anyway with the current taps. This occurs when upscaling with insufficient de_i gaps.
- Weights:
  - w1 = frac >> (log2(PIXEL_STEP) - (COE_WIDTH-1)); w0 = 2^(COE_WIDTH-1) - w1.
  - Per channel: sum = w0*t0 + w1*t1 + 2^(COE_WIDTH-2); out = sum >> (COE_WIDTH-1).
  - The result never exceeds 2^PIXEL_WIDTH - 1 by construction; no saturation logic is needed.
- Pipeline: stage E -> multiply -> add -> output register.
  - If the bracketing pixel is accepted at edge T, do_o/de_o are valid after edge T+4.
  - hs_o/vs_o are aligned with de_o of the first output of the line/frame.
  - de_o is a one-cycle strobe per output; do_o holds its value between strobes.
- Step 0 never advances cnt_o: output pixel 0 repeats until dst_width is reached. This is legal.
- Accumulator wrap is not supported. The host guarantees dst_width*step < 2^CNT_WIDTH.

Optional Feature:
Macro SCALER_H_INIT_PHASE_EN.
- Defined: adds input h_init_phase[15:0]. At line start cnt_o <= h_init_phase instead of 0, for centre-aligned sampling (typically (step-PIXEL_STEP)/2).
- Undefined: the port does not exist and cnt_o starts at 0.

Test Plan:
- Defaults, step 4096, dst_width 4, continuous de_i, ch0 = 0,100,200,300,400, ch1 = ch0+1, ch2 = ch0+2 -> ch0 outputs 0,100,200,300; ch1 1,101,201,301; first de_o 4 clocks after pixel 1 accepted; hs_o on first output.
- Step 2048 (2x up), de_i every other clock, input 0,100,200,300, dst_width 4 -> 0,50,100,150; overrun_o stays 0. Same stimulus with continuous de_i and dst_width 6 -> overrun_o = 1.
- Step 8192 (down), 8 inputs 0..700 by 100, dst_width 3 -> 0,200,400; de_o count 3.
- dst_width 6, line of 4 pixels, then next hs -> 3 outputs (0,100,200), line_short_o = 1; next vs line start clears it.
- rst pulse mid-line -> all outputs 0 immediately, no de_o until next de_i & hs_i; next line scales normally.
- SCALER_H_INIT_PHASE_EN defined, phase 2048, step 4096, input 0,100,200,300 -> 50,150,250.
